// File: rtl/led_pkg.sv
// Shared state encoding, default WS281x timing constants and counter-width helper
// for the LED frame sender.
package led_pkg;

  localparam int unsigned DEF_NBITS  = 120;
  localparam int unsigned DEF_T0H    = 40;
  localparam int unsigned DEF_T1H    = 80;
  localparam int unsigned DEF_TBIT   = 125;
  localparam int unsigned DEF_TLATCH = 5000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SEND  = 2'b01,
    LATCH = 2'b10
  } ledState_t;

  // Width of a counter holding 0..numStates-1; never narrower than one bit.
  function automatic int unsigned cntWidth(input int unsigned numStates);
    return (numStates > 1) ? $clog2(numStates) : 1;
  endfunction

endpackage

// File: rtl/ws_bit_timer.sv
// Per-bit NRZ waveform generator: counts the bit period and drives the registered
// high/low pulse for the bit selected by bit_val.
module ws_bit_timer
  import led_pkg::*;
#(
  parameter int unsigned TBIT = DEF_TBIT,
  parameter int unsigned T0H  = DEF_T0H,
  parameter int unsigned T1H  = DEF_T1H
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  input  logic bit_val,
  output logic pulse,
  output logic bit_end
);

  localparam int unsigned CW = cntWidth(TBIT);
  localparam int unsigned HW = CW + 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;
  logic [HW-1:0] highTime;

  assign bit_end = (cnt == CW'(TBIT - 1));

  // bit_val describes the bit that owns the next cycle, so the pulse flop
  // is loaded with the level that cycle must show.
  always_comb begin
    cntNext  = '0;
    highTime = bit_val ? HW'(T1H) : HW'(T0H);
    if (start) begin
      cntNext = '0;
    end else if (run) begin
      cntNext = bit_end ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      cnt   <= cntNext;
      pulse <= (start || run) && ({1'b0, cntNext} < highTime);
    end
  end

endmodule

// File: rtl/led_frame_sender.sv
// Serialises an NBITS frame onto a WS281x-style LED strip data line, then holds
// the line low for the latch period before accepting another frame.
module led_frame_sender
  import led_pkg::*;
#(
  parameter int unsigned NBITS  = DEF_NBITS,
  parameter int unsigned T0H    = DEF_T0H,
  parameter int unsigned T1H    = DEF_T1H,
  parameter int unsigned TBIT   = DEF_TBIT,
  parameter int unsigned TLATCH = DEF_TLATCH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [NBITS-1:0] frame,
  output logic             ready,
  output logic             dout,
  output logic             done
);

  localparam int unsigned IW = cntWidth(NBITS);
  localparam int unsigned LW = cntWidth(TLATCH);

  ledState_t        state;
  ledState_t        stateNext;
  logic [NBITS-1:0] shiftReg;
  logic [IW-1:0]    bitIdx;
  logic [LW-1:0]    latchCnt;
  logic [LW-1:0]    latchCntNext;
  logic             accept;
  logic             lastBitEnd;
  logic             latchEnd;
  logic             timerRun;
  logic             bitVal;
  logic             bitEnd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext  = state;
    accept     = 1'b0;
    lastBitEnd = 1'b0;
    latchEnd   = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          accept    = 1'b1;
          stateNext = SEND;
        end
      end
      SEND: begin
        if (bitEnd && (bitIdx == IW'(NBITS - 1))) begin
          lastBitEnd = 1'b1;
          stateNext  = LATCH;
        end
      end
      LATCH: begin
        if (latchCnt == LW'(TLATCH - 1)) begin
          latchEnd  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    latchCntNext = ((state == LATCH) && !latchEnd) ? latchCnt + LW'(1) : '0;
    timerRun     = (state == SEND) && !lastBitEnd;
    // Next cycle's bit: new frame MSB on accept, else the bit after a shift.
    bitVal = accept ? frame[NBITS-1] : (bitEnd ? shiftReg[NBITS-2] : shiftReg[NBITS-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shiftReg <= '0;
      bitIdx   <= '0;
      latchCnt <= '0;
      done     <= 1'b0;
      ready    <= 1'b1;
    end else begin
      latchCnt <= latchCntNext;
      ready    <= (stateNext == IDLE);
      done     <= (stateNext == LATCH) && (latchCntNext == LW'(TLATCH - 1));
      if (accept) begin
        shiftReg <= frame;
        bitIdx   <= '0;
      end else if ((state == SEND) && bitEnd) begin
        shiftReg <= shiftReg << 1;
        bitIdx   <= lastBitEnd ? '0 : bitIdx + IW'(1);
      end
    end
  end

  ws_bit_timer #(
    .TBIT (TBIT),
    .T0H  (T0H),
    .T1H  (T1H)
  ) u_bitTimer (
    .clk     (clk),
    .reset   (reset),
    .start   (accept),
    .run     (timerRun),
    .bit_val (bitVal),
    .pulse   (dout),
    .bit_end (bitEnd)
  );

endmodule

// File: tb/tb_led_frame_sender.sv
// Bench for led_frame_sender: a frame-level reference model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_led_frame_sender;

  localparam int NBITS  = 120;
  localparam int T0H    = 40;
  localparam int T1H    = 80;
  localparam int TBIT   = 125;
  localparam int TLATCH = 5000;
  localparam int TOTAL  = NBITS * TBIT + TLATCH;

  logic             clk;
  logic             reset;
  logic             go;
  logic [NBITS-1:0] frame;
  logic             ready;
  logic             dout;
  logic             done;

  int checks   = 0;
  int failures = 0;

  led_frame_sender dut (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .frame (frame),
    .ready (ready),
    .dout  (dout),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a frame is either idle or at cycle mK since acceptance.
  bit               mValid  = 1'b0;
  bit               mActive = 1'b0;
  int               mK      = 0;
  logic [NBITS-1:0] mFrame  = '0;

  always @(posedge clk) begin
    if (reset) begin
      mActive = 1'b0;
      mValid  = 1'b1;
    end else if (mValid) begin
      if (!mActive) begin
        if (go) begin
          mActive = 1'b1;
          mK      = 0;
          mFrame  = frame;
        end
      end else if (mK == TOTAL - 1) begin
        mActive = 1'b0;
      end else begin
        mK++;
      end
    end
  end

  logic eDout, eReady, eDone;
  int   eBit, ePhase;

  always @(negedge clk) begin
    if (mValid) begin
      if (!mActive) begin
        eDout  = 1'b0;
        eReady = 1'b1;
        eDone  = 1'b0;
      end else begin
        eReady = 1'b0;
        eDone  = (mK == TOTAL - 1);
        if (mK < NBITS * TBIT) begin
          eBit   = mK / TBIT;
          ePhase = mK % TBIT;
          eDout  = (ePhase < (mFrame[NBITS-1-eBit] ? T1H : T0H));
        end else begin
          eDout = 1'b0;
        end
      end
      checkBit("model_dout", dout, eDout);
      checkBit("model_ready", ready, eReady);
      checkBit("model_done", done, eDone);
    end
  end

  localparam logic [NBITS-1:0] FRAME_A = 120'hFF0000_00FF00_0000FF_FFFFFF_000000;
  localparam logic [NBITS-1:0] FRAME_B = 120'h00FF00_FF00FF_123456_ABCDEF_0F0F0F;
  localparam logic [NBITS-1:0] FRAME_X = 120'hA5A5A5_5A5A5A_C3C3C3_3C3C3C_F0F0F0;

  int hi [16];
  int lowCnt, doneAt, readyAt, doneSeen;
  int rises, runLen, maxRun, doneN, readyN;
  logic prevD;

  initial begin
    // Reset and go together: reset must win.
    reset = 1'b1;
    go    = 1'b1;
    frame = FRAME_B;
    @(negedge clk);
    checkBit("rst_go_ready", ready, 1'b1);
    checkBit("rst_go_dout", dout, 1'b0);
    checkBit("rst_go_done", done, 1'b0);
    reset = 1'b0;
    go    = 1'b0;
    @(negedge clk);
    checkBit("post_rst_dout", dout, 1'b0);
    checkBit("post_rst_ready", ready, 1'b1);

    // Frame aborted by reset at cycle 3000.
    frame = FRAME_X;
    go    = 1'b1;
    @(negedge clk);
    go = 1'b0;
    checkBit("first_cycle_high", dout, 1'b1);
    checkBit("busy_ready", ready, 1'b0);
    repeat (3000) @(negedge clk);
    checkBit("c3000_high", dout, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkBit("abort_dout", dout, 1'b0);
    checkBit("abort_ready", ready, 1'b1);
    doneSeen = 0;
    repeat (30) begin
      @(negedge clk);
      doneSeen += int'(done);
    end
    checkInt("abort_no_done", doneSeen, 0);

    // Clean frame A, with an ignored second go at cycle 500.
    frame = FRAME_A;
    go    = 1'b1;
    @(negedge clk);
    go      = 1'b0;
    frame   = FRAME_X;
    lowCnt  = 0;
    doneAt  = -1;
    readyAt = -1;
    for (int i = 0; i < 16; i++) hi[i] = 0;
    for (int k = 0; k <= TOTAL; k++) begin
      if (dout && k < 16 * TBIT) hi[k / TBIT]++;
      if (!dout && k >= NBITS * TBIT && k < TOTAL) lowCnt++;
      if (done && doneAt < 0) doneAt = k;
      if (ready && readyAt < 0) readyAt = k;
      if (k == 500) begin
        go    = 1'b1;
        frame = FRAME_B;
      end
      if (k == 501) go = 1'b0;
      if (k < TOTAL) @(negedge clk);
    end
    checkInt("bit0_high", hi[0], 80);
    checkInt("bit7_high", hi[7], 80);
    checkInt("bit8_high", hi[8], 40);
    checkInt("bit15_high", hi[15], 40);
    checkInt("latch_low", lowCnt, 5000);
    checkInt("done_cycle", doneAt, 19999);
    checkInt("ready_cycle", readyAt, 20000);

    // go held for 50000 cycles with an all-zero frame.
    frame  = '0;
    go     = 1'b1;
    prevD  = dout;
    rises  = 0;
    runLen = 0;
    maxRun = 0;
    doneN  = 0;
    readyN = 0;
    repeat (50000) begin
      @(negedge clk);
      if (dout) begin
        if (!prevD) rises++;
        runLen++;
        if (runLen > maxRun) maxRun = runLen;
      end else begin
        runLen = 0;
      end
      prevD = dout;
      doneN  += int'(done);
      readyN += int'(ready);
    end
    go = 1'b0;
    checkInt("held_rises", rises, 320);
    checkInt("held_max_high", maxRun, 40);
    checkInt("held_done_count", doneN, 2);
    checkInt("held_ready_cycles", readyN, 2);

    // Abort the third frame and confirm the line drops.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkBit("end_abort_dout", dout, 1'b0);
    checkBit("end_abort_ready", ready, 1'b1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
